raven_spi_slave: RTL and testbench
==================================

RAVEN_SPI_SLAVE -- requirements
Module: raven_spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on csb/sck/sdi (legal 2..3).
REQ-002 clk  input  1  system clock; sck frequency SHALL be at most clk/8.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 csb  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-005 sck  input  1  SPI clock, mode 0 (sample rising, shift falling).
REQ-006 sdi  input  1  SPI serial data in, MSB first.
REQ-007 sdo  output  1  SPI serial data out, MSB first.
REQ-008 sdo_oe  output  1  sdo output enable for the pad.
REQ-009 reg_addr  output  8  register address.
REQ-010 reg_wdata  output  8  write data.
REQ-011 reg_we  output  1  one-clk write strobe.
REQ-012 reg_re  output  1  one-clk read strobe.
REQ-013 reg_rdata  input  8  read data, valid the clk after reg_re.

Function
REQ-014 csb, sck, sdi SHALL each pass through SYNC_STAGES flops; all edges SHALL be detected on synchronized sck only.
REQ-015 States: IDLE, CMD, ADDR, DATA, IGNORE.
REQ-016 Synchronized csb high SHALL force IDLE, bit counter 0, sdo_oe 0 on the next clk, from any state, including mid-byte (partial byte discarded, no strobe).
REQ-017 Synchronized csb falling SHALL move IDLE -> CMD.
REQ-018 On each sck rising edge, sdi SHALL shift into rx register LSB end; 3-bit bit counter increments, wrapping 7 -> 0 marks byte complete.
REQ-019 CMD byte complete: 0x80 -> write mode, ADDR; 0x40 -> read mode, ADDR; any other value -> IGNORE until csb high.
REQ-020 ADDR byte complete: reg_addr <= byte; read mode pulses reg_re one clk later; state -> DATA.
REQ-021 DATA write: each completed byte SHALL load reg_wdata and pulse reg_we exactly one clk after the completing synced edge; reg_addr SHALL increment the clk after reg_we.
REQ-022 DATA read: clk after reg_re, reg_rdata SHALL load the tx register; sdo SHALL present tx[7] immediately and shift on each sck falling edge; after 8th rising edge, reg_addr increments and reg_re pulses again (prefetch).
REQ-023 reg_addr increment SHALL wrap 0xFF -> 0x00.
REQ-024 sdo_oe SHALL be 1 only in DATA with read mode and csb low; sdo SHALL be 0 whenever sdo_oe is 0.
REQ-025 reg_we and reg_re SHALL never assert in the same clk and never for more than one clk per byte.
REQ-026 sck edges while csb high SHALL be ignored.

Reset
REQ-027 While reset is high: state IDLE, bit counter 0, rx/tx 0x00, sdo 0, sdo_oe 0, reg_addr 0x00, reg_wdata 0x00, reg_we 0, reg_re 0, synchronizer flops csb=1, sck=0, sdi=0.
REQ-028 Reset deassertion mid-transaction SHALL require a fresh csb falling edge before any byte is accepted.

Structure
REQ-029 Package raven_spi_pkg SHALL hold the state enum and command constants CMD_WRITE=0x80, CMD_READ=0x40.
REQ-030 One sub-module raven_sync (parameterized N-flop synchronizer, reset value input) SHALL be instantiated per async input.

Verification
REQ-031 Write: csb low, bytes 0x80,0x10,0xA5,0x3C -> reg_we twice; (addr,data) = (0x10,0xA5) then (0x11,0x3C).
REQ-032 Read: bytes 0x40,0x20 with model returning addr^0xFF, clock 16 more bits -> sdo stream 0xDF then 0xDE, sdo_oe high throughout DATA.
REQ-033 Wrap: write 0x80,0xFF,0x01,0x02 -> writes at 0xFF then 0x00.
REQ-034 Abort: csb high after 5 bits of data byte -> no reg_we; next transaction 0x80,0x05,0x77 writes 0x77 to 0x05.
REQ-035 Bad command 0x55 followed by 3 bytes -> no strobes, sdo_oe stays 0.
REQ-036 Reset asserted mid-read -> all outputs zero within same clk's async window; no strobe until new csb falling edge.

Source files
------------

// File: rtl/raven_spi_pkg.sv
// Shared types and constants for the Raven SPI register slave.
// Holds the controller state encoding and the two recognised command bytes.
package raven_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h40;

    // Bits arrive MSB first, so each new bit enters at the LSB end.
    function automatic logic [7:0] shift_in(input logic [7:0] r, input logic b);
        return {r[6:0], b};
    endfunction

endpackage

// File: rtl/raven_sync.sv
// N-flop synchronizer for one asynchronous input; the reset value is
// selectable so an idle-high line such as chip select resets inactive.
module raven_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {N{rst_val}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/raven_spi_slave.sv
// Mode-0 SPI slave bridging a command/address/data byte protocol onto a
// simple 8-bit register bus with single-cycle write and read strobes.
module raven_spi_slave
    import raven_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       csb,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    logic csb_s;
    logic sck_s;
    logic sdi_s;

    raven_sync #(.N(SYNC_STAGES)) u_sync_csb (
        .clk     (clk),
        .rst     (reset),
        .rst_val (1'b1),
        .d       (csb),
        .q       (csb_s)
    );

    raven_sync #(.N(SYNC_STAGES)) u_sync_sck (
        .clk     (clk),
        .rst     (reset),
        .rst_val (1'b0),
        .d       (sck),
        .q       (sck_s)
    );

    raven_sync #(.N(SYNC_STAGES)) u_sync_sdi (
        .clk     (clk),
        .rst     (reset),
        .rst_val (1'b0),
        .d       (sdi),
        .q       (sdi_s)
    );

    state_e     state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] rx_q,        rx_d;
    logic [7:0] tx_q,        tx_d;
    logic       read_mode_q, read_mode_d;
    logic [7:0] reg_addr_q,  reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q,    reg_we_d;
    logic       reg_re_q,    reg_re_d;
    logic       load_q,      load_d;
    logic       sdo_oe_q,    sdo_oe_d;
    logic       sck_prev_q,  sck_prev_d;
    logic       csb_prev_q,  csb_prev_d;
    logic [2:0] settle_q,    settle_d;

    logic       sck_rise;
    logic       sck_fall;
    logic       csb_fall;
    logic       settled;
    logic       byte_done;
    logic [7:0] rx_byte;

    // The csb synchronizer resets high; if the pin is already low when reset
    // lifts, that flush looks like a falling edge. Edges are only trusted once
    // the chain and the edge-detect flop hold real pin samples.
    assign settled  = (settle_q == SETTLE);
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csb_fall = settled & csb_prev_q & ~csb_s;

    always_comb begin
        sck_prev_d = sck_s;
        csb_prev_d = csb_s;
        settle_d   = settled ? settle_q : settle_q + 3'd1;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        read_mode_d = read_mode_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        load_d      = reg_re_q;
        rx_byte     = shift_in(rx_q, sdi_s);
        byte_done   = sck_rise && (bit_cnt_q == 3'd7);

        if (reg_we_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end
        if (load_q) begin
            tx_d = reg_rdata;
        end

        if (csb_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
        end else begin
            if ((state_q != ST_IDLE) && sck_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                    if (csb_fall) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WRITE) begin
                            read_mode_d = 1'b0;
                            state_d     = ST_ADDR;
                        end else if (rx_byte == CMD_READ) begin
                            read_mode_d = 1'b1;
                            state_d     = ST_ADDR;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        reg_addr_d = rx_byte;
                        reg_re_d   = read_mode_q;
                        state_d    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        if (read_mode_q) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            reg_re_d   = 1'b1;
                        end else begin
                            reg_wdata_d = rx_byte;
                            reg_we_d    = 1'b1;
                        end
                    end
                    // The falling edge after a byte's last bit must not shift:
                    // the prefetched byte's MSB is already on sdo by then.
                    if (read_mode_q && sck_fall && (bit_cnt_q != 3'd0)) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        sdo_oe_d = (state_d == ST_DATA) && read_mode_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            read_mode_q <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            load_q      <= 1'b0;
            sdo_oe_q    <= 1'b0;
            sck_prev_q  <= 1'b0;
            csb_prev_q  <= 1'b1;
            settle_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            read_mode_q <= read_mode_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            load_q      <= load_d;
            sdo_oe_q    <= sdo_oe_d;
            sck_prev_q  <= sck_prev_d;
            csb_prev_q  <= csb_prev_d;
            settle_q    <= settle_d;
        end
    end

    assign sdo       = sdo_oe_q & tx_q[7];
    assign sdo_oe    = sdo_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;

endmodule

// File: tb/tb_raven_spi_slave.sv
// Randomized bench for raven_spi_slave: a transaction-level model predicts
// register writes, read strobes and the sdo byte stream for each SPI frame.
module tb_raven_spi_slave;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       csb;
    logic       sck;
    logic       sdi;
    logic       sdo;
    logic       sdo_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    always #5 clk = ~clk;

    raven_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (rst),
        .csb       (csb),
        .sck       (sck),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata)
    );

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_we_q[$];
    logic [8:0]  exp_re_q[$];
    logic [7:0]  mem [256];
    logic [7:0]  txb [16];
    logic        we_prev;
    logic        re_prev;
    logic [16:0] e_we;
    logic [8:0]  e_re;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Register file read port: data appears the clock after the strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) reg_rdata <= 8'h00;
        else if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Strobe scoreboard: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            we_prev = 1'b0;
            re_prev = 1'b0;
        end else begin
            if (reg_we) begin
                e_we = (exp_we_q.size() > 0) ? exp_we_q.pop_front() : 17'h10000;
                check_eq("we_addr_data", {15'd0, 1'b0, reg_addr, reg_wdata}, {15'd0, e_we});
                check_eq("we_re_overlap", {31'd0, reg_re}, 32'd0);
                check_eq("we_width", {31'd0, we_prev}, 32'd0);
            end
            if (reg_re) begin
                e_re = (exp_re_q.size() > 0) ? exp_re_q.pop_front() : 9'h100;
                check_eq("re_addr", {23'd0, 1'b0, reg_addr}, {23'd0, e_re});
                check_eq("re_width", {31'd0, re_prev}, 32'd0);
            end
            we_prev = reg_we;
            re_prev = reg_re;
        end
    end

    task automatic shift_bits(input logic [7:0] b, input int nbits, input logic oe_exp,
                              output logic [7:0] got);
        got = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            sdi = b[7-k];
            repeat (HALF) @(negedge clk);
            got = {got[6:0], sdo};
            check_eq("sdo_oe", {31'd0, sdo_oe}, {31'd0, oe_exp});
            if (!oe_exp) check_eq("sdo_quiet", {31'd0, sdo}, 32'd0);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // One frame: n whole bytes from txb, then 'extra' bits of txb[n] before csb rises.
    task automatic spi_txn(input int n, input int extra);
        logic       wr;
        logic       rd;
        logic [7:0] a;
        logic [7:0] ai;
        logic [7:0] got;
        wr = (n >= 2) && (txb[0] == 8'h80);
        rd = (n >= 2) && (txb[0] == 8'h40);
        a  = txb[1];
        if (wr) begin
            for (int i = 2; i < n; i++) begin
                ai = a + 8'(i - 2);
                exp_we_q.push_back({1'b0, ai, txb[i]});
            end
        end
        if (rd) begin
            for (int i = 0; i <= n - 2; i++) begin
                ai = a + 8'(i);
                exp_re_q.push_back({1'b0, ai});
            end
        end
        csb = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            shift_bits(txb[i], 8, rd && (i >= 2), got);
            if (rd && (i >= 2)) begin
                ai = a + 8'(i - 2);
                check_eq("sdo_byte", {24'd0, got}, {24'd0, mem[ai]});
            end
        end
        if (extra > 0) shift_bits(txb[n], extra, rd, got);
        repeat (HALF) @(negedge clk);
        csb = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("we_missing", exp_we_q.size(), 32'd0);
        check_eq("re_missing", exp_re_q.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] got;
        logic [7:0] b;
        int         n;
        int         extra;

        rst = 1'b1;
        csb = 1'b1;
        sck = 1'b0;
        sdi = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
        repeat (3) @(negedge clk);
        check_eq("rst_sdo", {31'd0, sdo}, 32'd0);
        check_eq("rst_sdo_oe", {31'd0, sdo_oe}, 32'd0);
        check_eq("rst_addr", {24'd0, reg_addr}, 32'd0);
        check_eq("rst_wdata", {24'd0, reg_wdata}, 32'd0);
        check_eq("rst_we", {31'd0, reg_we}, 32'd0);
        check_eq("rst_re", {31'd0, reg_re}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Two writes from one frame.
        txb[0] = 8'h80; txb[1] = 8'h10; txb[2] = 8'hA5; txb[3] = 8'h3C;
        spi_txn(4, 0);
        // Two reads with prefetch; memory returns addr^FF.
        txb[0] = 8'h40; txb[1] = 8'h20; txb[2] = 8'h00; txb[3] = 8'h00;
        spi_txn(4, 0);
        // Address wrap 0xFF -> 0x00.
        txb[0] = 8'h80; txb[1] = 8'hFF; txb[2] = 8'h01; txb[3] = 8'h02;
        spi_txn(4, 0);
        // Abort after 5 bits of a data byte, then a clean write.
        txb[0] = 8'h80; txb[1] = 8'h30; txb[2] = 8'hAB;
        spi_txn(2, 5);
        txb[0] = 8'h80; txb[1] = 8'h05; txb[2] = 8'h77;
        spi_txn(3, 0);
        // Unknown command is ignored for the rest of the frame.
        txb[0] = 8'h55; txb[1] = 8'h12; txb[2] = 8'h34; txb[3] = 8'h56;
        spi_txn(4, 0);

        // Randomized frames over a randomized register file.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: txb[0] = 8'h80;
                1: txb[0] = 8'h40;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h80 || b == 8'h40) b = 8'h55;
                    txb[0] = b;
                end
            endcase
            for (int i = 1; i < 8; i++) txb[i] = 8'($urandom_range(0, 255));
            n     = 2 + $urandom_range(0, 3);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            spi_txn(n, extra);
        end

        // Reset in the middle of a read data byte.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
        exp_re_q.push_back(9'h020);
        csb = 1'b0;
        repeat (6) @(negedge clk);
        shift_bits(8'h40, 8, 1'b0, got);
        shift_bits(8'h20, 8, 1'b0, got);
        shift_bits(8'h00, 3, 1'b1, got);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_sdo", {31'd0, sdo}, 32'd0);
        check_eq("arst_sdo_oe", {31'd0, sdo_oe}, 32'd0);
        check_eq("arst_addr", {24'd0, reg_addr}, 32'd0);
        check_eq("arst_wdata", {24'd0, reg_wdata}, 32'd0);
        check_eq("arst_we", {31'd0, reg_we}, 32'd0);
        check_eq("arst_re", {31'd0, reg_re}, 32'd0);
        check_eq("arst_re_queue", exp_re_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // csb still low: these bytes must be dropped without a fresh falling edge.
        repeat (4) @(negedge clk);
        shift_bits(8'h80, 8, 1'b0, got);
        shift_bits(8'h10, 8, 1'b0, got);
        shift_bits(8'h99, 8, 1'b0, got);
        repeat (HALF) @(negedge clk);
        csb = 1'b1;
        repeat (12) @(negedge clk);
        txb[0] = 8'h80; txb[1] = 8'h42; txb[2] = 8'h5A;
        spi_txn(3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
